// File: rtl/denoise_pkg.sv
// Shared encodings for the 3x3 denoiser: filter modes, channel codes, binomial kernel constants.
package denoise_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_MEAN   = 2'd1,
      MODE_BINOM  = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_t;

   typedef enum logic [2:0] {
      RED   = 3'd0,
      GREEN = 3'd1,
      BLUE  = 3'd2,
      VOID  = 3'd7
   } chan_t;

   localparam int W_CORNER    = 1;
   localparam int W_EDGE      = 2;
   localparam int W_CENTRE    = 4;
   localparam int BINOM_RND   = 8;
   localparam int BINOM_SHIFT = 4;
   localparam int MEAN_DIV    = 9;

   // Per-beat pipeline control that travels alongside the sample.
   typedef struct packed {
      logic  vld;
      logic  last;
      mode_t mode;
   } ctl_t;

   function automatic int binom_wt(input int col, input int row);
      if (col == 1 && row == 1)      return W_CENTRE;
      else if (col == 1 || row == 1) return W_EDGE;
      else                           return W_CORNER;
   endfunction

endpackage

// File: rtl/denoise_filt3x3_if.sv
// Sample-stream bundle between the ISP upstream driver (master) and the denoiser (slave).
interface denoise_filt3x3_if
   import denoise_pkg::*;
#(
   parameter int DW = 8,
   parameter int CW = 3
);
   mode_t         cfg_mode;
   logic [DW-1:0] pixel_in;
   logic          valid_in;
   logic [CW-1:0] color_in;
   logic          sof_in;
   logic          last_in;
   logic [DW-1:0] pixel_out;
   logic          valid_out;
   logic [CW-1:0] color_out;
   logic          last_out;
   logic          err;

   modport master (
      output cfg_mode, pixel_in, valid_in, color_in, sof_in, last_in,
      input  pixel_out, valid_out, color_out, last_out, err
   );

   modport slave (
      input  cfg_mode, pixel_in, valid_in, color_in, sof_in, last_in,
      output pixel_out, valid_out, color_out, last_out, err
   );
endinterface

// File: rtl/denoise_linebuf.sv
// Two-row line buffer packed into one RAM word {row-2, row-1}; registered read, 1-cycle latency.
// Read-then-write at one address per beat; no backpressure, idle when en is low.
module denoise_linebuf #(
   parameter int DW    = 8,
   parameter int DEPTH = 1920,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdat,
   output logic [DW-1:0] rd_row1,
   output logic [DW-1:0] rd_row2
);
   logic [2*DW-1:0] mem [DEPTH];
   logic [2*DW-1:0] rd_word;

   // The old row-1 sample ages into the row-2 slot as the new sample lands.
   always_ff @(posedge clk) begin
      if (en) begin
         rd_word   <= mem[addr];
         mem[addr] <= {mem[addr][DW-1:0], wdat};
      end
   end

   assign rd_row1 = rd_word[DW-1:0];
   assign rd_row2 = rd_word[2*DW-1:DW];
endmodule

// File: rtl/denoise_filt3x3.sv
// Streaming 3x3 denoiser (bypass / mean / binomial) on a channel-interleaved raster stream.
// Fixed 4-cycle latency per beat; no backpressure, input gaps propagate unchanged.
module denoise_filt3x3
   import denoise_pkg::*;
#(
   parameter int DW    = 8,
   parameter int CH    = 3,
   parameter int CW    = 3,
   parameter int IMG_W = 640
) (
   input  logic             clk,
   input  logic             rst_n,
   denoise_filt3x3_if.slave bus
);
   localparam int XW    = $clog2(IMG_W);
   localparam int DEPTH = IMG_W * CH;
   localparam int AW    = $clog2(DEPTH);
   localparam int SW    = DW + 4;

   logic [CW-1:0] ch_q, pos_ch;
   logic [XW-1:0] col_q, pos_col, width_q;
   logic [1:0]    row_q, pos_row;
   mode_t         mode_q, pos_mode;
   logic          err_q, err_new;
   logic          beat, sof, ch_end, forced, eol, byp, emit;
   logic [AW-1:0] lb_addr;
   logic [DW-1:0] lb_row1, lb_row2;

   assign beat = bus.valid_in;
   assign sof  = bus.valid_in & bus.sof_in;

   // Position of the current beat; a start-of-frame beat is always at the origin.
   always_comb begin
      pos_ch   = sof ? '0 : ch_q;
      pos_col  = sof ? '0 : col_q;
      pos_row  = sof ? '0 : row_q;
      pos_mode = mode_q;
      if (sof) pos_mode = (bus.cfg_mode == MODE_RSVD) ? MODE_BYPASS : bus.cfg_mode;
   end

   assign ch_end  = (pos_ch == CW'(CH - 1));
   assign forced  = ch_end & (pos_col == XW'(IMG_W - 1)) & ~bus.last_in;
   assign eol     = bus.last_in | forced;
   assign byp     = (pos_mode == MODE_BYPASS);
   assign emit    = byp | ((pos_row == 2'd2) & (pos_col >= XW'(2)));
   assign err_new = (bus.color_in != pos_ch) | (bus.last_in & ~ch_end) | forced |
                    (eol & (pos_row != 2'd0) & (pos_col != width_q));
   assign lb_addr = AW'(pos_col) * AW'(CH) + AW'(pos_ch);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_q    <= '0;
         col_q   <= '0;
         row_q   <= '0;
         width_q <= '0;
         mode_q  <= MODE_BYPASS;
         err_q   <= 1'b0;
      end else if (beat) begin
         ch_q   <= pos_ch + 1'b1;
         col_q  <= pos_col;
         row_q  <= pos_row;
         mode_q <= pos_mode;
         err_q  <= (err_q & ~sof) | err_new;
         if (eol) begin
            ch_q  <= '0;
            col_q <= '0;
            row_q <= (pos_row == 2'd2) ? 2'd2 : pos_row + 1'b1;
            if (pos_row == 2'd0) width_q <= pos_col;
         end else if (ch_end) begin
            ch_q  <= '0;
            col_q <= pos_col + 1'b1;
         end
      end
   end

   denoise_linebuf #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_linebuf (
      .clk     (clk),
      .en      (beat),
      .addr    (lb_addr),
      .wdat    (bus.pixel_in),
      .rd_row1 (lb_row1),
      .rd_row2 (lb_row2)
   );

   ctl_t          s1_ctl, s2_ctl, s3_ctl;
   logic          s1_beat;
   logic [DW-1:0] s1_pix, s2_pix, s3_pix;
   logic [CW-1:0] s1_ch, s2_ch, s3_ch;
   logic [SW-1:0] s3_sum, sum9, wsum;
   logic [DW-1:0] win  [CH][3][3];
   logic [DW-1:0] wsel [3][3];
   logic [DW-1:0] pix_o;
   logic [CW-1:0] col_o;
   logic          vld_o, last_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_ctl  <= '0;
         s1_beat <= 1'b0;
         s1_pix  <= '0;
         s1_ch   <= '0;
      end else begin
         s1_ctl.vld  <= beat & emit;
         s1_ctl.last <= beat & emit & (byp ? bus.last_in : eol);
         s1_ctl.mode <= pos_mode;
         s1_beat     <= beat;
         s1_pix      <= bus.pixel_in;
         s1_ch       <= pos_ch;
      end
   end

   // Window index [col][row]: col 2 and row 2 are the newest.
   always_ff @(posedge clk) begin
      for (int c = 0; c < CH; c++) begin
         if (s1_beat && s1_ch == CW'(c)) begin
            for (int r = 0; r < 3; r++) begin
               win[c][0][r] <= win[c][1][r];
               win[c][1][r] <= win[c][2][r];
            end
            win[c][2][0] <= lb_row2;
            win[c][2][1] <= lb_row1;
            win[c][2][2] <= s1_pix;
         end
      end
   end

   always_comb begin
      wsel = win[0];
      for (int c = 1; c < CH; c++) begin
         if (s2_ch == CW'(c)) wsel = win[c];
      end
      sum9 = '0;
      wsum = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            sum9 = sum9 + SW'(wsel[i][j]);
            wsum = wsum + SW'(wsel[i][j]) * SW'(binom_wt(i, j));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_ctl <= '0;
         s2_pix <= '0;
         s2_ch  <= '0;
         s3_ctl <= '0;
         s3_pix <= '0;
         s3_ch  <= '0;
         s3_sum <= '0;
         pix_o  <= '0;
         col_o  <= '0;
         vld_o  <= 1'b0;
         last_o <= 1'b0;
      end else begin
         s2_ctl <= s1_ctl;
         s2_pix <= s1_pix;
         s2_ch  <= s1_ch;
         s3_ctl <= s2_ctl;
         s3_pix <= s2_pix;
         s3_ch  <= s2_ch;
         s3_sum <= (s2_ctl.mode == MODE_BINOM) ? wsum : sum9;
         vld_o  <= s3_ctl.vld;
         last_o <= s3_ctl.last;
         col_o  <= s3_ch;
         case (s3_ctl.mode)
            MODE_MEAN:  pix_o <= DW'(s3_sum / SW'(MEAN_DIV));
            MODE_BINOM: pix_o <= DW'((s3_sum + SW'(BINOM_RND)) >> BINOM_SHIFT);
            default:    pix_o <= s3_pix;
         endcase
      end
   end

   assign bus.pixel_out = pix_o;
   assign bus.valid_out = vld_o;
   assign bus.color_out = col_o;
   assign bus.last_out  = last_o;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_denoise_filt3x3.sv
// Randomised bench for denoise_filt3x3 against a frame-level reference model of the 3x3 filters.
module tb_denoise_filt3x3;
   import denoise_pkg::*;

   typedef struct {
      int pix;
      int col;
      int last;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   n_out = 0;
   int   n_last = 0;
   int   img [6][9][3];
   int   row_w [6];
   int   row_last [6];
   exp_t exp_q [$];

   denoise_filt3x3_if #(.DW(8), .CW(3)) bus ();

   denoise_filt3x3 #(.DW(8), .CH(3), .CW(3), .IMG_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (bus.valid_out) begin
         exp_t e;
         n_out++;
         if (bus.last_out) n_last++;
         if (exp_q.size() == 0) begin
            check("unexpected_out", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("pixel", int'(bus.pixel_out), e.pix);
            check("color", int'(bus.color_out), e.col);
            check("last", int'(bus.last_out), e.last);
            check("latency", cyc, e.cyc);
         end
      end
   end

   task automatic set_frame(input int w, input int h);
      for (int r = 0; r < 6; r++) begin
         row_w[r]    = (r < h) ? w : 0;
         row_last[r] = 1;
      end
   endtask

   task automatic fill_const(input int rv, input int gv, input int bv);
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 9; c++) begin
            img[r][c][0] = rv;
            img[r][c][1] = gv;
            img[r][c][2] = bv;
         end
   endtask

   task automatic fill_rand();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 9; c++)
            for (int k = 0; k < 3; k++) img[r][c][k] = $urandom_range(1, 255);
   endtask

   // Drives the frame in raster order and queues the expected outputs from the image arrays.
   task automatic run_frame(input mode_t mode, input int h, input int gap_pct, input int max_beats);
      int  n, s, ws, p, wt, lst;
      bit  filt;
      n    = 0;
      filt = (mode == MODE_MEAN) || (mode == MODE_BINOM);
      n_out  = 0;
      n_last = 0;
      for (int r = 0; r < h; r++)
         for (int c = 0; c < row_w[r]; c++)
            for (int k = 0; k < 3; k++) begin
               if (n < max_beats) begin
                  for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++) begin
                     bus.valid_in = 1'b0;
                     bus.sof_in   = 1'b0;
                     bus.last_in  = 1'b0;
                     @(posedge clk);
                     #1;
                  end
                  lst = (c == row_w[r] - 1 && k == 2) ? 1 : 0;
                  bus.cfg_mode = mode;
                  bus.valid_in = 1'b1;
                  bus.pixel_in = 8'(img[r][c][k]);
                  bus.color_in = 3'(k);
                  bus.sof_in   = (n == 0);
                  bus.last_in  = (lst != 0) && (row_last[r] != 0);
                  if (!filt) begin
                     exp_q.push_back('{img[r][c][k], k, lst & row_last[r], cyc + 4});
                  end else if (r >= 2 && c >= 2) begin
                     s  = 0;
                     ws = 0;
                     for (int dr = 0; dr < 3; dr++)
                        for (int dc = 0; dc < 3; dc++) begin
                           p  = img[r - 2 + dr][c - 2 + dc][k];
                           wt = ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1);
                           s  += p;
                           ws += p * wt;
                        end
                     exp_q.push_back('{(mode == MODE_MEAN) ? s / 9 : (ws + 8) / 16, k, lst, cyc + 4});
                  end
                  @(posedge clk);
                  #1;
                  n++;
               end
            end
      bus.valid_in = 1'b0;
      bus.sof_in   = 1'b0;
      bus.last_in  = 1'b0;
   endtask

   task automatic drain(input string tag);
      repeat (8) @(posedge clk);
      #1;
      check(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int got;
      mode_t m;
      bus.cfg_mode = MODE_BYPASS;
      bus.pixel_in = '0;
      bus.valid_in = 1'b0;
      bus.color_in = '0;
      bus.sof_in   = 1'b0;
      bus.last_in  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", int'(bus.valid_out), 0);
      check("rst_pixel", int'(bus.pixel_out), 0);
      check("rst_last", int'(bus.last_out), 0);
      check("rst_err", int'(bus.err), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_valid", int'(bus.valid_out), 0);

      // Flat mean frame: output equals input per channel.
      fill_const(90, 18, 255);
      set_frame(5, 4);
      run_frame(MODE_MEAN, 4, 0, 1000);
      drain("mean_const_drain");
      check("mean_const_beats", n_out, 18);
      check("mean_const_lasts", n_last, 2);
      check("mean_const_err", int'(bus.err), 0);

      // Horizontal ramp on red only.
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 9; c++) begin
            img[r][c][0] = 10 * c;
            img[r][c][1] = 0;
            img[r][c][2] = 0;
         end
      set_frame(5, 3);
      run_frame(MODE_MEAN, 3, 0, 1000);
      drain("mean_ramp_drain");
      check("mean_ramp_beats", n_out, 9);

      // Binomial impulse response.
      fill_const(0, 0, 0);
      img[2][2][0] = 160;
      set_frame(5, 5);
      run_frame(MODE_BINOM, 5, 0, 1000);
      drain("binom_imp_drain");
      check("binom_imp_beats", n_out, 27);

      // Bypass with random gaps.
      fill_rand();
      set_frame(3, 2);
      run_frame(MODE_BYPASS, 2, 40, 1000);
      drain("bypass_drain");
      check("bypass_beats", n_out, 18);
      check("bypass_lasts", n_last, 2);

      // Random frames over all modes, including the reserved code.
      for (int t = 0; t < 6; t++) begin
         int w, h;
         fill_rand();
         w = $urandom_range(3, 8);
         h = $urandom_range(3, 5);
         m = mode_t'($urandom_range(0, 3));
         set_frame(w, h);
         run_frame(m, h, 25, 1000);
         drain("rand_drain");
         check("rand_err", int'(bus.err), 0);
      end

      // Second row one pixel short: sticky error, cleared by the next frame start.
      fill_rand();
      set_frame(5, 3);
      row_w[1] = 4;
      run_frame(MODE_BYPASS, 3, 0, 1000);
      drain("short_row_drain");
      check("short_row_err", int'(bus.err), 1);
      repeat (5) @(posedge clk);
      #1;
      check("short_row_err_held", int'(bus.err), 1);
      set_frame(3, 2);
      run_frame(MODE_BYPASS, 2, 0, 1000);
      drain("clear_drain");
      check("err_cleared", int'(bus.err), 0);

      // Nine columns without last_in overruns the 8-pixel row.
      fill_rand();
      set_frame(9, 1);
      row_last[0] = 0;
      run_frame(MODE_BYPASS, 1, 0, 1000);
      drain("forced_eol_drain");
      check("forced_eol_err", int'(bus.err), 1);

      // Asynchronous reset while output is streaming.
      fill_rand();
      set_frame(5, 4);
      run_frame(MODE_MEAN, 4, 0, 45);
      got = 0;
      for (int i = 0; i < 10 && got == 0; i++) begin
         @(negedge clk);
         got = int'(bus.valid_out);
      end
      check("pre_rst_valid", got, 1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_valid", int'(bus.valid_out), 0);
      check("async_rst_pixel", int'(bus.pixel_out), 0);
      check("async_rst_last", int'(bus.last_out), 0);
      check("async_rst_color", int'(bus.color_out), 0);
      check("async_rst_err", int'(bus.err), 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      fill_rand();
      set_frame(5, 4);
      run_frame(MODE_MEAN, 4, 0, 1000);
      drain("post_rst_drain");
      check("post_rst_beats", n_out, 18);
      check("post_rst_err", int'(bus.err), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/denoise_filt3x3.md
Name: denoise_filt3x3

Overview:
- Parametrised successor to the fixed 6-row RGB box denoiser.
- Streaming 3x3 spatial filter on a raster-order, channel-interleaved pixel stream: one channel sample per valid beat, CH channels per pixel, rows terminated by last_in.
- Supports runtime mode selection (bypass, 3x3 mean, 3x3 binomial/Gaussian) and any row width up to IMG_W.
- Sits in the ISP chain between demosaic and colour correction.

Parameters:
- DW, 8, sample bit depth.
- CH, 3, channels per pixel; channel codes 0..CH-1.
- CW, 3, width of color_in/color_out.
- IMG_W, 640, maximum pixels per row; sets line-buffer depth.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_mode  in  2  0=bypass, 1=mean, 2=binomial, 3=reserved (treated as bypass); sampled on frame start.
- pixel_in  in  DW  input sample.
- valid_in  in  1  sample qualifier; gaps allowed anywhere.
- color_in  in  CW  channel code; must equal beat index mod CH.
- sof_in  in  1  first beat of frame (with valid_in).
- last_in  in  1  final beat of row (channel CH-1, with valid_in).
- pixel_out  out  DW  filtered sample.
- valid_out  out  1  output qualifier.
- color_out  out  CW  channel code of pixel_out.
- last_out  out  1  final beat of output row.
- err  out  1  sticky protocol error; cleared by sof_in or reset.

Behaviour:
- Reset (async, rst_n low): all outputs 0, counters 0, row count 0, mode=bypass. Line-buffer contents are don't-care; they are never read before being rewritten, because output is gated by row/column counts.
- Counters (advance only on valid_in): ch_idx 0..CH-1; col increments after ch_idx==CH-1; row increments on last_in. sof_in forces ch_idx=col=row=0, latches cfg_mode, and clears err.
- Row width: latched from col at the first last_in of the frame.
- Later row ending at a different width: err=1; the row is still processed at its actual length.
- col reaching IMG_W without last_in: forced end-of-row, err=1.
- color_in != ch_idx: err=1; ch_idx remains authoritative.
- Storage:
  - Two line buffers, each IMG_W*CH entries of DW.
  - Per channel, a 3x3 window register, shifted on that channel's beat.
  - Read and write use the same address (col*CH+ch_idx); write-after-read each beat.
- Filter modes:
  - mean: sum9 is DW+4 bits; out = floor(sum9/9), a constant divide.
  - binomial: weights 1 2 1 / 2 4 2 / 1 2 1, wsum is DW+4 bits; out = (wsum+8)>>4.
  - Results always fit in DW; no saturation needed.
- Output window:
  - Filter modes emit only for input beats with row>=2 and col>=2; the window is centred on (row-1, col-1), so the output frame is (W-2)x(H-2).
  - Bypass emits every input beat unchanged.
- last_out: on the channel CH-1 beat of the final column of each output row; in bypass it mirrors last_in.
- Latency: fixed 4 cycles from a valid_in beat to its valid_out beat in every mode. Stages: input register, buffer read/window shift, add tree, divide/round plus output register. Gaps propagate unchanged.
- Mid-frame sof_in: abandons the current frame; row/col restart; no partial-row flush.
- Async reset mid-frame: pipeline is discarded; valid_out drops immediately.

Decomposition:
- Package denoise_pkg holds:
  - mode encodings MODE_BYPASS/MODE_MEAN/MODE_BINOM;
  - channel codes RED/GREEN/BLUE/VOID;
  - binomial weights and rounding constant.
- One sub-module, denoise_linebuf: parametrised dual-row line buffer (depth IMG_W*CH, width DW), one read/write port pair, inferred RAM.

Test Plan:
- Mean, 5x4 frame, IMG_W=8, every pixel R=90 G=18 B=255 -> 18 valid_out beats repeating 90,18,255; last_out on beats 9 and 18; err=0.
- Mean, 5x3 frame, R=10*col, G=B=0 -> exactly 3 pixels, R outputs 10,20,30, G/B 0; first valid_out 4 cycles after the input beat at row 2 col 2.
- Binomial, 5x5 frame of zeros with R=160 at (2,2) -> R at centre output 40, edge-adjacent 20, corners 10; all G/B 0.
- Bypass, 3x2 frame with random valid_in gaps -> output equals input beat-for-beat, delayed 4 cycles; last_out aligned with last_in.
- Second row 1 pixel shorter than the first -> err=1 and held; the next sof_in clears it. Separately, 9 columns with no last_in (IMG_W=8) -> forced EOL, err=1.
- rst_n pulsed low mid-frame while valid_out=1 -> all outputs 0 asynchronously; a new frame after release produces correct mean values.
